// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Fetch stage between the BPU/ICache and the instruction buffer. Holds the
// fetch PC and issues one dual-word ICache request at a time. It folds in
// the branch prediction for each requested pair. Each returned pair goes to
// the instruction buffer one cycle after icache_data_ok_i. Valid strobes are
// held for a single cycle.
//
// Optional feature: define FETCH_BPU_EN to use the branch predictor. When
// the macro is undefined, predictions are ignored and the PC always
// advances by 8.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush, flush_pc          pipeline redirect and its target
//   buffer_full_i            instruction buffer near-full, blocks new requests
//   bpu_pc_o                 BPU lookup address (same as icache_addr_o)
//   bpu_taken_i/target_i/select_i  prediction for the pair at bpu_pc_o
//   icache_req_o/addr_o      request handshake towards the ICache
//   icache_addr_ok_i         request accepted this cycle
//   icache_data_ok_i         data for the oldest accepted request
//   icache_inst1_i/inst2_i   returned instruction words
//   inst1_o/inst2_o, inst1_addr_o/inst2_addr_o  delivered words and PCs
//   inst1_valid_o/inst2_valid_o  one-cycle write strobes
//   only_delayslot_inst_o    delivered pair carries only the delay slot
//   bpu_predict_info_o       {taken, target} of the delivered pair
//   bpu_select_o             branch slot of the delivered pair

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        buffer_full_i,
  output logic [31:0] bpu_pc_o,
  input  logic        bpu_taken_i,
  input  logic [31:0] bpu_target_i,
  input  logic        bpu_select_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_addr_ok_i,
  input  logic        icache_data_ok_i,
  input  logic [31:0] icache_inst1_i,
  input  logic [31:0] icache_inst2_i,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic [31:0] inst1_addr_o,
  output logic [31:0] inst2_addr_o,
  output logic        inst1_valid_o,
  output logic        inst2_valid_o,
  output logic        only_delayslot_inst_o,
  output logic [32:0] bpu_predict_info_o,
  output logic        bpu_select_o
);

  typedef enum logic {RUN, DSLOT} state_t;

`ifdef FETCH_BPU_EN
  localparam logic BPU_EN = 1'b1;
`else
  localparam logic BPU_EN = 1'b0;
`endif

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] dslot_target;
  logic        outstanding;
  logic        discard;

  logic [31:0] meta_pc;
  logic        meta_taken;
  logic [31:0] meta_target;
  logic        meta_select;
  logic        meta_dslot;

  logic        taken;
  logic        req;
  logic        accept;
  logic        resp;

  assign taken  = BPU_EN & bpu_taken_i;
  assign accept = req & icache_addr_ok_i;
  // A data_ok with nothing outstanding can only be a leftover from before a
  // reset, so it is ignored.
  assign resp   = icache_data_ok_i & outstanding;

  assign icache_req_o  = req;
  assign icache_addr_o = pc;
  assign bpu_pc_o      = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state. A taken branch in the second slot leaves its delay slot
  // unfetched, so one extra single-word fetch is inserted before the target.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RUN;
    end else if (accept) begin
      case (state)
        RUN:   if (taken && bpu_select_i) state_next = DSLOT;
        DSLOT: state_next = RUN;
      endcase
    end
  end

  // Request output. The slot freed by a returning response can be reused
  // in the same cycle.
  always_comb begin
    req = !rst && !flush && !buffer_full_i && (!outstanding || icache_data_ok_i);
  end

  // PC, request tracking and per-request metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      dslot_target <= 32'd0;
      outstanding  <= 1'b0;
      discard      <= 1'b0;
      meta_pc      <= 32'd0;
      meta_taken   <= 1'b0;
      meta_target  <= 32'd0;
      meta_select  <= 1'b0;
      meta_dslot   <= 1'b0;
    end else begin
      if (flush) begin
        pc <= flush_pc;
      end else if (accept) begin
        if (state == DSLOT)                pc <= dslot_target;
        else if (taken && !bpu_select_i)   pc <= bpu_target_i;
        else                               pc <= pc + 32'd8;
      end

      if (accept && state == RUN && taken && bpu_select_i)
        dslot_target <= bpu_target_i;

      if (accept)    outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      // Data already in flight at a flush belongs to the old path. When it
      // arrives in the flush cycle itself, it is dropped directly instead.
      if (flush && outstanding && !icache_data_ok_i) discard <= 1'b1;
      else if (resp)                                 discard <= 1'b0;

      if (accept) begin
        meta_pc <= pc;
        if (state == DSLOT) begin
          meta_taken  <= 1'b0;
          meta_target <= 32'd0;
          meta_select <= 1'b0;
          meta_dslot  <= 1'b1;
        end else begin
          meta_taken  <= taken;
          meta_target <= bpu_target_i;
          meta_select <= taken & bpu_select_i;
          meta_dslot  <= 1'b0;
        end
      end
    end
  end

  // Delivery to the instruction buffer. Strobes last one cycle. Data and
  // address fields keep their last delivered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst1_o               <= 32'd0;
      inst2_o               <= 32'd0;
      inst1_addr_o          <= 32'd0;
      inst2_addr_o          <= 32'd0;
      inst1_valid_o         <= 1'b0;
      inst2_valid_o         <= 1'b0;
      only_delayslot_inst_o <= 1'b0;
      bpu_predict_info_o    <= 33'd0;
      bpu_select_o          <= 1'b0;
    end else begin
      inst1_valid_o         <= 1'b0;
      inst2_valid_o         <= 1'b0;
      only_delayslot_inst_o <= 1'b0;
      if (resp && !discard && !flush) begin
        inst1_o               <= icache_inst1_i;
        inst2_o               <= icache_inst2_i;
        inst1_addr_o          <= meta_pc;
        inst2_addr_o          <= meta_pc + 32'd4;
        inst1_valid_o         <= 1'b1;
        inst2_valid_o         <= !meta_dslot;
        only_delayslot_inst_o <= meta_dslot;
        bpu_predict_info_o    <= meta_taken ? {1'b1, meta_target} : 33'd0;
        bpu_select_o          <= meta_select;
      end
    end
  end

endmodule
